// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit MIPS unicycle datapath.
//   PC_WIDTH   : default width of PC, offsets, jump targets and link register
//   RESET_ADDR : default PC value loaded by reset
//   state_e    : fetch state machine encoding (run / halt)
//   pc_sel_e   : next-PC source select encoding
package mips_pkg;

  localparam int unsigned PC_WIDTH = 8;
  localparam logic [PC_WIDTH-1:0] RESET_ADDR = 8'h00;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_INC = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/branch_target_adder.sv
// Modulo adder for relative branch targets.
//   i_base   : pc + 1
//   i_offset : sign-extended two's complement offset
//   o_target : (i_base + i_offset) mod 2^W, carry discarded
module branch_target_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_offset,
  output logic [W-1:0] o_target
);

  // Two's complement wraparound makes a plain W-bit add correct for negative offsets.
  assign o_target = i_base + i_offset;

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: PC register, next-PC priority select, single-entry
// link register, RUN/HALT fetch state machine and saturating retire counter.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   stall              : freeze all state this cycle
//   branch, zero       : conditional branch taken when both high
//   branch_offset      : sign-extended relative offset
//   jump, link         : absolute jump to jump_addr; link saves pc_plus1 (jal)
//   jump_reg           : jump to link register (jr)
//   jump_addr          : absolute jump target
//   halt               : stop fetch until reset
//   pc, pc_plus1       : current PC (registered), PC + 1 (combinational)
//   link_reg, halted   : link register, HALT state flag
//   retired            : saturating count of PC updates
module pc_next_unit #(
  parameter int unsigned               PC_WIDTH   = mips_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]       RESET_ADDR = mips_pkg::RESET_ADDR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch,
  input  logic                zero,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jump,
  input  logic                link,
  input  logic                jump_reg,
  input  logic [PC_WIDTH-1:0] jump_addr,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic [PC_WIDTH-1:0] link_reg,
  output logic                halted,
  output logic [7:0]          retired
);

  import mips_pkg::*;

  state_e              r_state;
  state_e              w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_link;
  logic [7:0]          r_retired;

  logic [PC_WIDTH-1:0] w_pc_plus1;
  logic [PC_WIDTH-1:0] w_br_target;
  logic [PC_WIDTH-1:0] w_pc_next;
  pc_sel_e             w_sel;
  logic                w_advance;
  logic                w_do_link;

  assign w_pc_plus1 = r_pc + PC_WIDTH'(1);

  branch_target_adder #(
    .W (PC_WIDTH)
  ) u_branch_target_adder (
    .i_base   (w_pc_plus1),
    .i_offset (branch_offset),
    .o_target (w_br_target)
  );

  // Fixed priority: jr > jump > taken branch > increment.
  always_comb begin
    w_sel = SEL_INC;
    if (jump_reg) begin
      w_sel = SEL_JR;
    end else if (jump) begin
      w_sel = SEL_JMP;
    end else if (branch && zero) begin
      w_sel = SEL_BR;
    end
  end

  always_comb begin
    w_pc_next = w_pc_plus1;
    unique case (w_sel)
      SEL_INC: w_pc_next = w_pc_plus1;
      SEL_BR:  w_pc_next = w_br_target;
      SEL_JMP: w_pc_next = jump_addr;
      SEL_JR:  w_pc_next = r_link;
      default: w_pc_next = w_pc_plus1;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; stall masks halt.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:   if (!stall && halt) w_state_next = StHalt;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StRun;
    endcase
  end

  // State-machine outputs: when the datapath registers may update.
  always_comb begin
    w_advance = 1'b0;
    w_do_link = 1'b0;
    unique case (r_state)
      StRun: begin
        w_advance = !stall && !halt;
        // jr wins over jump, so jr+link never writes the link register.
        w_do_link = w_advance && (w_sel == SEL_JMP) && link;
      end
      default: begin
        w_advance = 1'b0;
        w_do_link = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= RESET_ADDR;
      r_link    <= '0;
      r_retired <= '0;
    end else begin
      if (w_advance) begin
        r_pc <= w_pc_next;
        if (r_retired != 8'hFF) begin
          r_retired <= r_retired + 8'd1;
        end
      end
      if (w_do_link) begin
        r_link <= w_pc_plus1;
      end
    end
  end

  assign pc       = r_pc;
  assign pc_plus1 = w_pc_plus1;
  assign link_reg = r_link;
  assign halted   = (r_state == StHalt);
  assign retired  = r_retired;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       stall;
  logic       branch;
  logic       zero;
  logic [7:0] branch_offset;
  logic       jump;
  logic       link;
  logic       jump_reg;
  logic [7:0] jump_addr;
  logic       halt;
  logic [7:0] pc;
  logic [7:0] pc_plus1;
  logic [7:0] link_reg;
  logic       halted;
  logic [7:0] retired;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  pc_next_unit dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .jump          (jump),
    .link          (link),
    .jump_reg      (jump_reg),
    .jump_addr     (jump_addr),
    .halt          (halt),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .link_reg      (link_reg),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clock = ~clock;

  // One rising edge; returns 1 time unit later so outputs are sampled off-edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; branch = 0; zero = 0; branch_offset = 8'h00;
    jump = 0; link = 0; jump_reg = 0; jump_addr = 8'h00; halt = 0;
  endtask

  task automatic goto(input logic [7:0] a);
    idle_inputs();
    jump = 1; jump_addr = a;
    cyc();
    exp_ret++;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    cyc();
    reset = 0;
    exp_ret = 0;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 8'h00); end
    checks++; if (link_reg !== 8'h00) begin errors++; $display("FAIL reset_link got %h exp %h", link_reg, 8'h00); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (retired !== 8'h00) begin errors++; $display("FAIL reset_retired got %h exp 00", retired); end
    checks++; if (pc_plus1 !== 8'h01) begin errors++; $display("FAIL reset_pc_plus1 got %h exp 01", pc_plus1); end
  endtask

  task automatic test_increment();
    logic [7:0] exp_pc [3] = '{8'h01, 8'h02, 8'h03};
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL inc_pc[%0d] got %h exp %h", i, pc, exp_pc[i]); end
    end
    exp_ret = 3;
    checks++; if (retired !== 8'd3) begin errors++; $display("FAIL inc_retired got %0d exp 3", retired); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL inc_halted got %b exp 0", halted); end
  endtask

  task automatic test_branch();
    goto(8'h10);
    branch = 1; zero = 1; branch_offset = 8'hFD;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h0E) begin errors++; $display("FAIL br_taken got %h exp 0E", pc); end
    goto(8'h10);
    branch = 1; zero = 0; branch_offset = 8'h05;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h11) begin errors++; $display("FAIL br_not_taken got %h exp 11", pc); end
    idle_inputs();
    checks++; if (retired !== exp_ret[7:0]) begin errors++; $display("FAIL br_retired got %0d exp %0d", retired, exp_ret); end
  endtask

  task automatic test_jal_jr();
    goto(8'h20);
    jump = 1; link = 1; jump_addr = 8'h40;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jal_pc got %h exp 40", pc); end
    checks++; if (link_reg !== 8'h21) begin errors++; $display("FAIL jal_link got %h exp 21", link_reg); end
    idle_inputs();
    jump_reg = 1;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h21) begin errors++; $display("FAIL jr_pc got %h exp 21", pc); end
    // link alone: plain increment, link register untouched
    idle_inputs();
    link = 1;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h22) begin errors++; $display("FAIL link_only_pc got %h exp 22", pc); end
    checks++; if (link_reg !== 8'h21) begin errors++; $display("FAIL link_only_link got %h exp 21", link_reg); end
    // jr with link: returns to 21, link register not overwritten with 23
    link = 1; jump_reg = 1;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h21) begin errors++; $display("FAIL jr_link_pc got %h exp 21", pc); end
    checks++; if (link_reg !== 8'h21) begin errors++; $display("FAIL jr_link_link got %h exp 21", link_reg); end
    idle_inputs();
  endtask

  task automatic test_priority_stall();
    goto(8'h05);
    jump = 1; branch = 1; zero = 1; branch_offset = 8'h01; jump_addr = 8'h80;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h80) begin errors++; $display("FAIL prio_jump got %h exp 80", pc); end
    jump_reg = 1; jump_addr = 8'h90;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h21) begin errors++; $display("FAIL prio_jr got %h exp 21", pc); end
    goto(8'h80);
    stall = 1; jump = 1; jump_addr = 8'h55; link = 1; halt = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (pc !== 8'h80) begin errors++; $display("FAIL stall_pc[%0d] got %h exp 80", i, pc); end
    end
    checks++; if (retired !== exp_ret[7:0]) begin errors++; $display("FAIL stall_retired got %0d exp %0d", retired, exp_ret); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL stall_halt got %b exp 0", halted); end
    checks++; if (link_reg !== 8'h21) begin errors++; $display("FAIL stall_link got %h exp 21", link_reg); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    goto(8'hFF);
    checks++; if (pc_plus1 !== 8'h00) begin errors++; $display("FAIL wrap_plus1 got %h exp 00", pc_plus1); end
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h exp 00", pc); end
    goto(8'hF8);
    branch = 1; zero = 1; branch_offset = 8'h0F;
    cyc(); exp_ret++;
    checks++; if (pc !== 8'h08) begin errors++; $display("FAIL wrap_branch got %h exp 08", pc); end
    idle_inputs();
  endtask

  task automatic test_saturate();
    idle_inputs();
    for (int i = 0; i < 300; i++) cyc();
    checks++; if (retired !== 8'hFF) begin errors++; $display("FAIL sat_retired got %h exp FF", retired); end
  endtask

  task automatic test_halt();
    idle_inputs();
    reset = 1; cyc(); reset = 0;
    goto(8'h30);
    halt = 1;
    cyc();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
    checks++; if (pc !== 8'h30) begin errors++; $display("FAIL halt_pc got %h exp 30", pc); end
    checks++; if (retired !== 8'd1) begin errors++; $display("FAIL halt_retired got %0d exp 1", retired); end
    halt = 0; jump_addr = 8'h77;
    for (int i = 0; i < 4; i++) begin
      jump = ~jump;
      cyc();
      checks++; if (pc !== 8'h30) begin errors++; $display("FAIL halt_hold_pc[%0d] got %h exp 30", i, pc); end
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold got %b exp 1", halted); end
    stall = 1; reset = 1;
    cyc();
    idle_inputs();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL halt_reset_pc got %h exp 00", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset_flag got %b exp 0", halted); end
    checks++; if (retired !== 8'h00) begin errors++; $display("FAIL halt_reset_retired got %h exp 00", retired); end
    cyc();
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL post_reset_run got %h exp 01", pc); end
  endtask

  initial begin
    #2;
    test_reset();
    test_increment();
    test_branch();
    test_jal_jr();
    test_priority_stall();
    test_wrap();
    test_saturate();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
